// File: rtl/seg7_pkg.sv
// Purpose : shared types and constants for the seven-segment scan driver.
// Latency : n/a (package only).
// Backpressure: n/a. Provides request FSM states, digit count, segment codes, glyph table.
package seg7_pkg;

    // Conversion request FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } req_state_e;

    localparam int NUM_DIGITS = 4;

    // Segment codes are {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    // Glyphs for 0..9; element [n] is the pattern for digit n.
    localparam logic [9:0][6:0] SEG_GLYPH = {
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// Purpose : nibble to active-low seven-segment pattern; 10..15 render as a dash.
// Latency : combinational, zero cycles.
// Backpressure: none. Ports: nib_i (4-bit digit value), seg_o ({g,f,e,d,c,b,a}, active-low).
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        if (nib_i <= 4'd9) begin
            seg_o = SEG_GLYPH[nib_i];
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Purpose : paces BCD conversions, captures results, scans 4 digits onto a common-anode display.
// Latency : an/seg registered, 1 cycle after the digit index or captured value changes.
// Backpressure: none; one request outstanding, abandoned after WAIT_TIMEOUT+1 wait cycles.
//
// Ports: clk/rst (sync, active-high); bcd_in/bcd_valid from converter; conv_en request pulse;
//        an (active-low anodes, an[0]=units), seg ({g,f,e,d,c,b,a} active-low), dp (always off).
// Build option: define SEG7_LZ_BLANK_EN to blank leading-zero digits (digit 0 always lit).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV   = 100000,
    parameter int UPDATE_FRAMES = 50,
    parameter int WAIT_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic        bcd_valid,
    output logic        conv_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int DIV_W  = $clog2(REFRESH_DIV);
    localparam int FRM_W  = (UPDATE_FRAMES < 2) ? 1 : $clog2(UPDATE_FRAMES);
    localparam int WAIT_W = (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(UPDATE_FRAMES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT);

    logic [DIV_W-1:0]  div_cnt_q,   div_cnt_d;
    logic [1:0]        digit_idx_q, digit_idx_d;
    logic [15:0]       disp_q,      disp_d;
    logic [3:0]        an_q,        an_d;
    logic [6:0]        seg_q,       seg_d;
    logic              dp_q;

    req_state_e        state_q;
    logic [FRM_W-1:0]  frame_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              conv_en_q;

    logic              tick;
    logic              frame_end;
    logic [3:0]        cur_nib;
    logic              blank;

    assign tick      = (div_cnt_q == DIV_LAST);
    assign frame_end = tick && (digit_idx_q == 2'(NUM_DIGITS - 1));

    // Nibble currently being shown; decoded once for the whole display.
    assign cur_nib = disp_q[{digit_idx_q, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .nib_i (cur_nib),
        .seg_o (seg_d)
    );

`ifdef SEG7_LZ_BLANK_EN
    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        blank = 1'b0;
        case (digit_idx_q)
            2'd1:    blank = (disp_q[15:4]  == 12'h000);
            2'd2:    blank = (disp_q[15:8]  == 8'h00);
            2'd3:    blank = (disp_q[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
        digit_idx_d = tick ? digit_idx_q + 2'd1 : digit_idx_q;
        disp_d      = bcd_valid ? bcd_in : disp_q;
        an_d        = blank ? 4'hF : ~(4'b0001 << digit_idx_q);
    end

    // Scan datapath and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q   <= '0;
            digit_idx_q <= 2'd0;
            disp_q      <= 16'h0000;
            an_q        <= 4'hF;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
        end else begin
            div_cnt_q   <= div_cnt_d;
            digit_idx_q <= digit_idx_d;
            disp_q      <= disp_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= 1'b1;
        end
    end

    // Request FSM. conv_en is registered on entry to REQ so it is high for
    // exactly the single REQ cycle. Frames only count while IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            wait_cnt_q  <= '0;
            conv_en_q   <= 1'b0;
        end else begin
            conv_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_end) begin
                        if (frame_cnt_q == FRM_LAST) begin
                            frame_cnt_q <= '0;
                            state_q     <= REQ;
                            conv_en_q   <= 1'b1;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end
                    end
                end
                REQ: begin
                    state_q    <= WAIT;
                    wait_cnt_q <= '0;
                end
                WAIT: begin
                    // A reply and a timeout in the same cycle both end the wait.
                    if (bcd_valid || (wait_cnt_q == WAIT_LAST)) begin
                        state_q <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign conv_en = conv_en_q;
    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Purpose : self-checking bench for seg7_scan_driver with a timeline reference model.
// Latency : n/a.
// Backpressure: n/a. Two instances (long and short wait timeout) share clock and stimulus.
module tb_seg7_scan_driver;

    localparam int RD  = 4;
    localparam int UF  = 2;
    localparam int FRM = 4 * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = 16'h0000;
    logic        bcd_valid = 1'b0;

    logic       conv_a, conv_b, dp_a, dp_b;
    logic [3:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;

    logic       conv_o [2];
    logic       dp_o   [2];
    logic [3:0] an_o   [2];
    logic [6:0] seg_o  [2];

    assign conv_o[0] = conv_a; assign conv_o[1] = conv_b;
    assign dp_o[0]   = dp_a;   assign dp_o[1]   = dp_b;
    assign an_o[0]   = an_a;   assign an_o[1]   = an_b;
    assign seg_o[0]  = seg_a;  assign seg_o[1]  = seg_b;

    seg7_scan_driver #(.REFRESH_DIV(RD), .UPDATE_FRAMES(UF), .WAIT_TIMEOUT(255)) dut_a (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
        .conv_en(conv_a), .an(an_a), .seg(seg_a), .dp(dp_a)
    );

    seg7_scan_driver #(.REFRESH_DIV(RD), .UPDATE_FRAMES(UF), .WAIT_TIMEOUT(10)) dut_b (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
        .conv_en(conv_b), .an(an_b), .seg(seg_b), .dp(dp_b)
    );

    always #5 clk = ~clk;

    // Reference model: time is counted in clock edges since reset release.
    int          total = 0;
    int          bad   = 0;
    int          t     = 0;
    logic [15:0] m_disp = 16'h0000;
    int          wt        [2];
    bit          pending   [2];
    int          next_req  [2];
    int          req_cycle [2];
    int          last_conv [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, t);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0: glyph = 7'h40;
            4'd1: glyph = 7'h79;
            4'd2: glyph = 7'h24;
            4'd3: glyph = 7'h30;
            4'd4: glyph = 7'h19;
            4'd5: glyph = 7'h12;
            4'd6: glyph = 7'h02;
            4'd7: glyph = 7'h78;
            4'd8: glyph = 7'h00;
            4'd9: glyph = 7'h10;
            default: glyph = 7'h3F;
        endcase
    endfunction

    // Apply inputs for one edge, advance the model, compare every output.
    task automatic step(input bit r, input bit v, input logic [15:0] d);
        logic [15:0] old;
        int          idx;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        bit          e_conv [2];
        rst = r; bcd_valid = v; bcd_in = d;
        @(posedge clk); #1;
        if (r) begin
            t = 0;
            m_disp = 16'h0000;
            e_an = 4'hF;
            e_seg = 7'h7F;
            for (int i = 0; i < 2; i++) begin
                pending[i]  = 1'b0;
                next_req[i] = UF * FRM;
                e_conv[i]   = 1'b0;
            end
        end else begin
            old = m_disp;
            t++;
            idx   = ((t - 1) / RD) % 4;
            e_seg = glyph(old[idx*4 +: 4]);
            e_an  = ~(4'b0001 << idx);
`ifdef SEG7_LZ_BLANK_EN
            if (idx > 0 && (old >> (4 * idx)) == 16'h0000) e_an = 4'hF;
`endif
            for (int i = 0; i < 2; i++) begin
                e_conv[i] = 1'b0;
                if (!pending[i]) begin
                    if (t == next_req[i]) begin
                        pending[i]   = 1'b1;
                        req_cycle[i] = t;
                        e_conv[i]    = 1'b1;
                        last_conv[i] = t + 1;  // conv_en is high during cycle t+1
                    end
                end else if (t > req_cycle[i] + 1) begin
                    // Waited cycles before this edge: t - req_cycle - 2.
                    if (v || (t - req_cycle[i] - 2) == wt[i]) begin
                        pending[i]  = 1'b0;
                        next_req[i] = (t / FRM + UF) * FRM;
                    end
                end
            end
            if (v) m_disp = d;
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("an[%0d]", i), 32'(an_o[i]), 32'(e_an));
            if (r || e_an != 4'hF) chk($sformatf("seg[%0d]", i), 32'(seg_o[i]), 32'(e_seg));
            chk($sformatf("dp[%0d]", i), 32'(dp_o[i]), 32'd1);
            chk($sformatf("conv_en[%0d]", i), 32'(conv_o[i]), 32'(e_conv[i]));
        end
    endtask

    initial begin
        logic [3:0]  lit;
        logic [15:0] d;
        bit          r, v;
        wt[0] = 255; wt[1] = 10;
        last_conv[0] = -1; last_conv[1] = -1;

        // Reset held three cycles; a converter pulse during reset must be dropped.
        step(1, 0, 16'h0000);
        step(1, 1, 16'h9999);
        step(1, 0, 16'h0000);
        chk("rst_an", 32'(an_a), 32'hF);
        chk("rst_seg", 32'(seg_a), 32'h7F);
        chk("rst_dp", 32'(dp_a), 32'd1);
        chk("rst_conv", 32'(conv_a), 32'd0);

        // Scan 1234, run up to the first request.
        step(0, 1, 16'h1234);
        repeat (31) step(0, 0, 16'h0000);
        chk("first_conv_cycle_a", 32'(last_conv[0]), 32'd33);
        chk("first_conv_cycle_b", 32'(last_conv[1]), 32'd33);

        // Reply 27 cycles after the request with an invalid tens nibble.
        repeat (26) step(0, 0, 16'h0000);
        step(0, 1, 16'h00A5);
        repeat (31) step(0, 0, 16'h0000);
        chk("next_conv_after_reply", 32'(last_conv[0]), 32'd81);
        chk("next_conv_after_timeout", 32'(last_conv[1]), 32'd65);

        // dut_a is in WAIT now: reset drops the request and clears the display.
        step(1, 1, 16'h5555);
        chk("rst_wait_conv", 32'(conv_a), 32'd0);
        step(0, 0, 16'h0000);
        chk("rst_wait_disp0", 32'(seg_a), 32'h40);
        chk("rst_wait_an", 32'(an_a), 32'hE);

        // Leading-zero behaviour on 0007.
        step(0, 1, 16'h0007);
        lit = 4'h0;
        repeat (2 * FRM) begin
            step(0, 0, 16'h0000);
            lit = lit | ~an_a;
        end
`ifdef SEG7_LZ_BLANK_EN
        chk("lz_lit_mask", 32'(lit), 32'h1);
`else
        chk("lz_lit_mask", 32'(lit), 32'hF);
`endif

        // Randomised traffic: replies, unsolicited pulses, occasional resets.
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 599) == 0);
            v = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0) d = 16'($urandom);
            else d = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                      4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 5) == 0) d = d & 16'h000F;
            step(r, v, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
